// File: rtl/clk_div_sched.sv
// clk_div_sched: programmable integer clock divider. It produces a divide-by-N
// clock, a one-cycle enable per divided period and a bypass select. Ratio
// changes arrive over a valid/ready handshake and are applied only on a
// divided-period boundary, so the divided clock never glitches.
module clk_div_sched #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_done,
  output logic             o_div_clk,
  output logic             o_clk_en,
  output logic             o_bypass,
  output logic             o_active
);

  typedef enum logic [1:0] {OFF, BYP, DIV} state_t;

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_W = (DIV_W+1)'(1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cur, cur_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] pend, pend_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             done_q, done_nxt;
  logic             div_clk_q, div_clk_nxt;
  logic             accept, boundary, apply;
  logic [DIV_W-1:0] apply_div;
  logic [DIV_W:0]   half;

  // The applied ratio alone determines which mode the divider runs in.
  function automatic state_t decode(input logic [DIV_W-1:0] n);
    if (n == '0)       return OFF;
    else if (n == ONE) return BYP;
    else               return DIV;
  endfunction

  // Next-state logic: count, capture offers, and apply ratios on boundaries.
  // The divided clock is computed one cycle ahead so it comes straight off a flop.
  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    cnt_nxt      = cnt;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    done_nxt     = 1'b0;
    apply        = 1'b0;
    apply_div    = i_cfg_div;
    accept       = i_cfg_valid && !pend_vld;
    boundary     = (state == DIV) && (cnt == cur - ONE);

    unique case (state)
      OFF, BYP: begin
        cnt_nxt = '0;
        if (accept) begin
          apply     = 1'b1;
          apply_div = i_cfg_div;
        end
      end
      DIV: begin
        if (boundary) begin
          cnt_nxt = '0;
          if (pend_vld) begin
            apply     = 1'b1;
            apply_div = pend;
          end else if (accept) begin
            apply     = 1'b1;
            apply_div = i_cfg_div;
          end
        end else begin
          cnt_nxt = cnt + ONE;
          if (accept) begin
            pend_nxt     = i_cfg_div;
            pend_vld_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = OFF;
        cnt_nxt   = '0;
      end
    endcase

    if (apply) begin
      cur_nxt      = apply_div;
      cnt_nxt      = '0;
      pend_vld_nxt = 1'b0;
      done_nxt     = 1'b1;
      state_nxt    = decode(apply_div);
    end

    half        = ({1'b0, cur_nxt} + ONE_W) >> 1;
    div_clk_nxt = (state_nxt == DIV) && ({1'b0, cnt_nxt} < half);
  end

  // State register with synchronous reset; reset drops any pending ratio.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= OFF;
      cur       <= '0;
      cnt       <= '0;
      pend      <= '0;
      pend_vld  <= 1'b0;
      done_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      pend_vld  <= pend_vld_nxt;
      done_q    <= done_nxt;
      div_clk_q <= div_clk_nxt;
    end
  end

  assign o_cfg_ready = !pend_vld;
  assign o_cfg_done  = done_q;
  assign o_div_clk   = div_clk_q;
  assign o_clk_en    = (state == BYP) || boundary;
  assign o_bypass    = (state == BYP);
  assign o_active    = (state != OFF);

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed and random stimulus for clk_div_sched, compared
// every cycle against a period-position model of the divider.
module tb_clk_div_sched;

  logic       i_clk;
  logic       i_rst;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_div;
  logic       o_cfg_ready, o_cfg_done, o_div_clk, o_clk_en, o_bypass, o_active;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: applied ratio, position within the divided period,
  // pending offer and the done pulse expected in the current cycle.
  int m_n       = 0;
  int m_pos     = 0;
  int m_pend    = 0;
  bit m_pv      = 0;
  bit m_done    = 0;

  clk_div_sched #(.DIV_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_ready (o_cfg_ready),
    .o_cfg_done  (o_cfg_done),
    .o_div_clk   (o_div_clk),
    .o_clk_en    (o_clk_en),
    .o_bypass    (o_bypass),
    .o_active    (o_active)
  );

  // Free-running source clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %b expected %b (n=%0d pos=%0d)", tag, obs, exp, m_n, m_pos);
      end
  endtask

  task automatic checkOutput();
    chk("ready",   o_cfg_ready, !m_pv);
    chk("done",    o_cfg_done,  m_done);
    chk("div_clk", o_div_clk,   (m_n >= 2) && (m_pos < (m_n + 1) / 2));
    chk("clk_en",  o_clk_en,    (m_n == 1) || ((m_n >= 2) && (m_pos == m_n - 1)));
    chk("bypass",  o_bypass,    m_n == 1);
    chk("active",  o_active,    m_n != 0);
  endtask

  // Advance the model by one source-clock cycle given the inputs at that edge.
  task automatic modelCycle(input bit rst, input bit vld, input int div);
    bit acc, last;
    if (rst) begin
      m_n = 0; m_pos = 0; m_pv = 0; m_done = 0;
      return;
    end
    acc    = vld && !m_pv;
    m_done = 0;
    if (m_n < 2) begin
      m_pos = 0;
      if (acc) begin m_n = div; m_pos = 0; m_done = 1; end
    end else begin
      last = (m_pos == m_n - 1);
      if (last && (m_pv || acc)) begin
        m_n = m_pv ? m_pend : div; m_pos = 0; m_done = 1; m_pv = 0;
      end else begin
        m_pos = last ? 0 : m_pos + 1;
        if (acc) begin m_pv = 1; m_pend = div; end
      end
    end
  endtask

  // One cycle: check outputs mid-cycle, drive inputs, take the edge, update model.
  task automatic applyStimulus(input bit rst, input bit vld, input int div);
    checkOutput();
    i_rst       = rst;
    i_cfg_valid = vld;
    i_cfg_div   = 8'(div);
    @(posedge i_clk);
    modelCycle(rst, vld, div);
    @(negedge i_clk);
    i_cfg_valid = 1'b0;
    i_rst       = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, 0);
  endtask

  // Hold an offer until the model says it was accepted (bounded).
  task automatic offer(input int div);
    bit acc;
    for (int i = 0; i < 600; i++) begin
      acc = !m_pv;
      applyStimulus(0, 1, div);
      if (acc) return;
    end
    chk("offer_timeout", 1'b1, 1'b0);
  endtask

  // Idle until the model reaches a given period position (bounded).
  task automatic waitPos(input int pos);
    for (int i = 0; i < 600; i++) begin
      if (m_n >= 2 && m_pos == pos) return;
      applyStimulus(0, 0, 0);
    end
    chk("wait_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    int hi;
    int r;
    int d;
    i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_div = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset state, then N=4.
    idle(2);
    offer(4);
    idle(9);

    // N=4 running, N=3 offered at position 1.
    waitPos(1);
    offer(3);
    idle(8);

    // N=5, then N=0 offered at the last position of the period.
    offer(5);
    waitPos(4);
    offer(0);
    idle(3);

    // Bypass, then N=255 with high-phase count.
    offer(1);
    idle(4);
    offer(255);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      hi += int'(o_div_clk);
      applyStimulus(0, 0, 0);
    end
    compared++;
    assert (hi === 128)
      else begin
        mismatched++;
        $error("[TB] FAIL high_count: observed %0d expected 128", hi);
      end

    // N=6 running, N=2 pending, reset before the boundary.
    offer(6);
    waitPos(0);
    offer(2);
    idle(1);
    applyStimulus(1, 0, 0);
    idle(3);

    // Back-to-back offers while one is pending.
    offer(4);
    waitPos(1);
    applyStimulus(0, 1, 3);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 7);
    idle(20);

    // Randomized offers, ratios and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      d = (r < 8) ? r : ((r == 8) ? 255 : int'($urandom_range(0, 255)));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, d);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
